mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined RV32 core.
- Data accesses have fixed priority. A streak counter bounds fetch starvation.
- Holds the memory-side request stable until the memory handshakes, then returns a registered response.
- A watchdog converts a hung memory into an error response.

---
 rtl/riscv_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/arb_watchdog.sv | 26 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } arb_state_t;

  // Wide enough for DATA_STREAK_MAX up to 15 and TIMEOUT up to 255.
  localparam int STREAK_W = 4;
  localparam int TIMER_W  = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              err;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, err,
           mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_watchdog.sv
// Busy-cycle counter; expired flags the last cycle allowed before a timeout.
module arb_watchdog
  import riscv_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == TIMER_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters,
// data first with a bounded streak, registered responses and a hang watchdog.
module mem_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);
  arb_state_t          state_reg, state_next;
  logic [STREAK_W-1:0] streak_reg, streak_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                resp_d_reg, resp_d_next;
  logic                err_reg, err_next;
  logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic [DATA_W-1:0]   resp_data;
  logic                in_busy;
  logic                expired;

  assign in_busy = (state_reg == BUSY_I) || (state_reg == BUSY_D);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_busy || bus.mem_ready || expired),
    .enable  (in_busy),
    .expired (expired)
  );

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    resp_d_next    = resp_d_reg;
    err_next       = err_reg;
    if_rdata_next  = if_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    resp_data      = '0;
    case (state_reg)
      IDLE: begin
        // A full streak with a waiting fetch hands this slot to the fetch.
        if (bus.d_req && !(bus.if_req && streak_reg == STREAK_W'(DATA_STREAK_MAX))) begin
          state_next     = BUSY_D;
          mem_we_next    = bus.d_we;
          mem_addr_next  = bus.d_addr;
          mem_wdata_next = bus.d_wdata;
          streak_next    = bus.if_req ? streak_reg + 1'b1 : '0;
        end else if (bus.if_req) begin
          state_next    = BUSY_I;
          mem_we_next   = 1'b0;
          mem_addr_next = bus.if_addr;
          streak_next   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready || expired) begin
          state_next  = RESP;
          resp_d_next = (state_reg == BUSY_D);
          err_next    = !bus.mem_ready;
          if (bus.mem_ready && !mem_we_reg) begin
            resp_data = bus.mem_rdata;
          end
          if (state_reg == BUSY_D) begin
            d_rdata_next = resp_data;
          end else begin
            if_rdata_next = resp_data;
          end
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      resp_d_reg    <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      resp_d_reg    <= resp_d_next;
      err_reg       <= err_next;
      if_rdata_reg  <= if_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign bus.mem_valid = in_busy;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_ready  = (state_reg == RESP) && !resp_d_reg;
  assign bus.d_ready   = (state_reg == RESP) && resp_d_reg;
  assign bus.err       = (state_reg == RESP) && err_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the memory port arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DATA_STREAK_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the grant, holds the request for lat cycles, then answers with rdata.
  task automatic serve(input int lat, input logic [31:0] rdata,
                       output logic [31:0] addr_seen, output logic we_seen,
                       output logic [31:0] wdata_seen, output int wait_cyc,
                       output logic stable);
    wait_cyc = 0;
    stable   = 1'b1;
    while (!bus.mem_valid && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    addr_seen  = bus.mem_addr;
    we_seen    = bus.mem_we;
    wdata_seen = bus.mem_wdata;
    if (!bus.mem_valid) begin
      chk("grant_wait", bus.mem_valid, 1);
      return;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      if (!bus.mem_valid || bus.mem_addr !== addr_seen || bus.mem_we !== we_seen ||
          bus.mem_wdata !== wdata_seen)
        stable = 1'b0;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    $display("txn addr=0x%08h we=%0d wdata=0x%08h lat=%0d wait=%0d", addr_seen, we_seen,
             wdata_seen, lat, wait_cyc);
  endtask

  logic [31:0] addr_s, wdata_s;
  logic        we_s, stable_s, seen_ready;
  int          wait_s, busy_cyc;
  logic        exp_is_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_ready = 0; bus.mem_rdata = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    reset = 1'b1;
    tick();

    // Fetch only, memory answers 2 cycles after mem_valid
    bus.if_req = 1; bus.if_addr = 32'h100;
    serve(2, 32'h0050_0093, addr_s, we_s, wdata_s, wait_s, stable_s);
    bus.if_req = 0;
    chk("fetch_wait", wait_s, 1);
    chk("fetch_addr", addr_s, 32'h100);
    chk("fetch_we", we_s, 0);
    chk("fetch_stable", stable_s, 1);
    chk("fetch_if_ready", bus.if_ready, 1);
    chk("fetch_d_ready", bus.d_ready, 0);
    chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
    chk("fetch_err", bus.err, 0);
    chk("fetch_resp_valid", bus.mem_valid, 0);
    tick();
    chk("fetch_pulse_end", bus.if_ready, 0);
    chk("fetch_idle", busy, 0);
    chk("fetch_rdata_hold", bus.if_rdata, 32'h0050_0093);

    // Data priority over a simultaneous fetch
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
    serve(1, 32'hCAFE_0001, addr_s, we_s, wdata_s, wait_s, stable_s);
    bus.d_req = 0;
    chk("prio_first_addr", addr_s, 32'h2000);
    chk("prio_d_ready", bus.d_ready, 1);
    chk("prio_if_ready", bus.if_ready, 0);
    chk("prio_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    serve(1, 32'h0000_0013, addr_s, we_s, wdata_s, wait_s, stable_s);
    bus.if_req = 0;
    chk("prio_fetch_wait", wait_s, 2);
    chk("prio_fetch_addr", addr_s, 32'h104);
    chk("prio_fetch_ready", bus.if_ready, 1);
    chk("prio_fetch_rdata", bus.if_rdata, 32'h0000_0013);
    chk("prio_d_rdata_hold", bus.d_rdata, 32'hCAFE_0001);
    tick();

    // Store path, memory answers 5 cycles after mem_valid
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF;
    serve(5, 32'h1234_5678, addr_s, we_s, wdata_s, wait_s, stable_s);
    bus.d_req = 0; bus.d_we = 0;
    chk("store_addr", addr_s, 32'h2004);
    chk("store_we", we_s, 1);
    chk("store_wdata", wdata_s, 32'hDEAD_BEEF);
    chk("store_stable", stable_s, 1);
    chk("store_d_ready", bus.d_ready, 1);
    chk("store_d_rdata", bus.d_rdata, 0);
    chk("store_err", bus.err, 0);
    tick();
    chk("store_pulse_end", bus.d_ready, 0);

    // Starvation bound: four data grants, one fetch, then data again
    bus.if_req = 1; bus.if_addr = 32'h108;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000;
    for (int k = 0; k < 6; k++) begin
      serve(0, 32'h1000 + k, addr_s, we_s, wdata_s, wait_s, stable_s);
      chk($sformatf("starve_addr%0d", k), addr_s, exp_is_d[k] ? 32'h3000 : 32'h108);
      chk($sformatf("starve_d_ready%0d", k), bus.d_ready, exp_is_d[k]);
      chk($sformatf("starve_if_ready%0d", k), bus.if_ready, !exp_is_d[k]);
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("starve_if_rdata", bus.if_rdata, 32'h1004);
    chk("starve_d_rdata", bus.d_rdata, 32'h1005);
    tick();

    // Timeout: memory never answers
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h4000;
    tick();
    chk("to_granted", bus.mem_valid, 1);
    busy_cyc = 0;
    while (bus.mem_valid && busy_cyc < 20) begin
      busy_cyc++;
      tick();
    end
    bus.d_req = 0;
    $display("txn addr=0x00004000 timeout busy_cycles=%0d", busy_cyc);
    chk("to_busy_cycles", busy_cyc, 8);
    chk("to_d_ready", bus.d_ready, 1);
    chk("to_err", bus.err, 1);
    chk("to_d_rdata", bus.d_rdata, 0);
    tick();
    chk("to_idle", busy, 0);
    chk("to_err_clear", bus.err, 0);

    // Reset in the middle of a data access, then a late mem_ready
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h5000;
    tick();
    chk("mr_granted", bus.mem_valid, 1);
    tick();
    reset = 1'b0; bus.d_req = 0;
    tick();
    chk("mr_valid_dropped", bus.mem_valid, 0);
    chk("mr_busy", busy, 0);
    reset = 1'b1;
    tick();
    bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_ready = 0; bus.mem_rdata = '0;
    seen_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.d_ready || bus.if_ready || bus.mem_valid || busy) seen_ready = 1'b1;
      tick();
    end
    $display("txn addr=0x00005000 abandoned by reset");
    chk("mr_no_activity", seen_ready, 0);
    chk("mr_d_rdata", bus.d_rdata, 0);
    chk("mr_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
